// File: rtl/psum_sc_buffer.sv
// Partial-sum scratch buffer: accumulates signed partial sums per address with
// saturation, then drains entries 0..hi_addr over a valid/ready stream.
module psum_sc_buffer #(
  parameter int PSUM_SC_ADDR_LEN = 8,
  parameter int PSUM_W           = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        psum_sc_wen,
  input  logic [PSUM_SC_ADDR_LEN-1:0] psum_sc_cnt_lead,
  input  logic [PSUM_W-1:0]           psum_in,
  input  logic                        psum_sc_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PSUM_W-1:0]           out_data,
  output logic [PSUM_SC_ADDR_LEN-1:0] out_addr,
  output logic                        out_last,
  output logic                        busy,
  output logic                        sat_flag,
  output logic                        wr_err
);

  localparam int DEPTH = 2 ** PSUM_SC_ADDR_LEN;

  typedef enum logic [1:0] {ACCUM, DRAIN, CLEAR} state_t;

  state_t                      state, state_next;
  logic [PSUM_W-1:0]           mem [DEPTH];
  logic [DEPTH-1:0]            occupied;
  logic [PSUM_SC_ADDR_LEN-1:0] hi_addr;
  logic [PSUM_SC_ADDR_LEN-1:0] ptr;
  logic [PSUM_SC_ADDR_LEN-1:0] load_addr;
  logic                        accept_wr;
  logic                        hit;
  logic [PSUM_W:0]             sum;
  logic                        sat;
  logic [PSUM_W-1:0]           wr_data;
  logic                        transfer;
  logic                        load;

  assign busy      = (state != ACCUM);
  assign accept_wr = (state == ACCUM) && psum_sc_wen;
  assign hit       = occupied[psum_sc_cnt_lead];
  assign transfer  = out_valid && out_ready;
  // A new beat is fetched on entry to DRAIN and after every non-final transfer,
  // so ptr always names the entry currently on out_*.
  assign load      = (state == DRAIN) && (!out_valid || (transfer && !out_last));
  assign load_addr = out_valid ? ptr + 1'b1 : ptr;

  // Sign-extend both operands by one bit; overflow shows as a mismatch of the top two bits.
  always_comb begin
    sum     = {mem[psum_sc_cnt_lead][PSUM_W-1], mem[psum_sc_cnt_lead]}
            + {psum_in[PSUM_W-1], psum_in};
    sat     = hit && (sum[PSUM_W] != sum[PSUM_W-1]);
    wr_data = psum_in;
    if (hit) begin
      if (sat)
        wr_data = sum[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
      else
        wr_data = sum[PSUM_W-1:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (psum_sc_done) state_next = ((|occupied) || accept_wr) ? DRAIN : CLEAR;
      DRAIN: if (transfer && out_last) state_next = CLEAR;
      CLEAR: state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  // Contents are only meaningful where occupied is set, so the array has no reset.
  always_ff @(posedge clk) begin
    if (accept_wr) mem[psum_sc_cnt_lead] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupied  <= '0;
      hi_addr   <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      if (busy && psum_sc_wen) wr_err <= 1'b1;
      case (state)
        ACCUM: begin
          if (accept_wr) begin
            occupied[psum_sc_cnt_lead] <= 1'b1;
            if (psum_sc_cnt_lead > hi_addr) hi_addr <= psum_sc_cnt_lead;
            if (sat) sat_flag <= 1'b1;
          end
          if (psum_sc_done) ptr <= '0;
        end
        DRAIN: begin
          if (load) begin
            ptr       <= load_addr;
            out_valid <= 1'b1;
            out_addr  <= load_addr;
            out_data  <= occupied[load_addr] ? mem[load_addr] : '0;
            out_last  <= (load_addr == hi_addr);
          end else if (transfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        CLEAR: begin
          occupied <= '0;
          hi_addr  <= '0;
          ptr      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_sc_buffer.sv
// Directed bench for psum_sc_buffer: expected beats are queued when stimulus is
// driven and checked as the stream produces them.
module tb_psum_sc_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psum_sc_wen = 1'b0;
  logic [7:0]  psum_sc_cnt_lead = '0;
  logic [15:0] psum_in = '0;
  logic        psum_sc_done = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [7:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        sat_flag;
  logic        wr_err;

  int tests = 0;
  int fails = 0;
  int xfer_cnt = 0;
  logic [24:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [24:0] held = '0;

  psum_sc_buffer #(.PSUM_SC_ADDR_LEN(8), .PSUM_W(16)) dut (
    .clk(clk), .rst(rst), .psum_sc_wen(psum_sc_wen), .psum_sc_cnt_lead(psum_sc_cnt_lead),
    .psum_in(psum_in), .psum_sc_done(psum_sc_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .sat_flag(sat_flag), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [24:0] pack(input int a, input int d, input bit l);
    return {a[7:0], d[15:0], l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int v);
    psum_sc_wen      = 1'b1;
    psum_sc_cnt_lead = a[7:0];
    psum_in          = v[15:0];
    tick();
    psum_sc_wen = 1'b0;
  endtask

  task automatic done_pulse();
    psum_sc_done = 1'b1;
    tick();
    psum_sc_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      tick();
      n++;
    end while ((busy || out_valid) && n < 300);
    check("drain_timeout", {31'd0, n < 300}, 32'd1);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  // Stream monitor: one line per transfer, plus hold/stability checks on stalls.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("valid_held", {31'd0, out_valid}, 32'd1);
        check("stall_stable", {7'd0, out_addr, out_data, out_last}, {7'd0, held});
      end
      if (out_valid && out_ready) begin
        $display("[TB] beat addr=%0d data=%0d last=%0b", out_addr, $signed(out_data), out_last);
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'd0, 32'd1);
        end else begin
          check("beat", {7'd0, out_addr, out_data, out_last}, {7'd0, exp_q.pop_front()});
        end
        xfer_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      held = {out_addr, out_data, out_last};
    end
  end

  initial begin
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    int n;
    int base;
    int busy_cycles;

    // Reset state
    repeat (3) tick();
    check("reset_outputs", {3'd0, out_valid, out_last, out_addr, out_data, busy, sat_flag, wr_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Accumulate to addr3, drain 0..3
    exp_q.push_back(pack(0, 0, 0));
    exp_q.push_back(pack(1, 0, 0));
    exp_q.push_back(pack(2, 0, 0));
    exp_q.push_back(pack(3, 70, 1));
    wr(3, 100);
    wr(3, -30);
    done_pulse();
    check("busy_in_drain", {31'd0, busy}, 32'd1);
    wait_idle();
    check("sat_clear", {31'd0, sat_flag}, 32'd0);

    // Positive and negative saturation
    exp_q.push_back(pack(0, 32767, 1));
    wr(0, 32000);
    wr(0, 1000);
    done_pulse();
    wait_idle();
    check("sat_set", {31'd0, sat_flag}, 32'd1);
    exp_q.push_back(pack(0, -32768, 1));
    wr(0, -32000);
    wr(0, -1000);
    done_pulse();
    wait_idle();

    // Backpressure with a toggling ready
    exp_q.push_back(pack(0, 11, 0));
    exp_q.push_back(pack(1, 22, 0));
    exp_q.push_back(pack(2, 33, 1));
    wr(0, 11);
    wr(1, 22);
    wr(2, 33);
    out_ready = 1'b0;
    base = xfer_cnt;
    done_pulse();
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("valid_rise", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i];
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
    check("xfer_count", xfer_cnt - base, 32'd3);

    // Write in the same cycle as done, then a rejected write during drain
    for (int i = 0; i < 5; i++) exp_q.push_back(pack(i, 0, 0));
    exp_q.push_back(pack(5, 7, 1));
    out_ready = 1'b0;
    psum_sc_done = 1'b1;
    wr(5, 7);
    psum_sc_done = 1'b0;
    check("wr_err_clear", {31'd0, wr_err}, 32'd0);
    psum_sc_done = 1'b1;
    wr(5, 100);
    psum_sc_done = 1'b0;
    check("wr_err_set", {31'd0, wr_err}, 32'd1);
    out_ready = 1'b1;
    wait_idle();

    // Done on an empty buffer: CLEAR only
    done_pulse();
    busy_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy) busy_cycles++;
      tick();
    end
    check("empty_busy_cycles", busy_cycles, 32'd1);
    check("empty_queue", exp_q.size(), 32'd0);

    // Reset in the middle of a drain
    exp_q.push_back(pack(0, 0, 0));
    exp_q.push_back(pack(1, 0, 0));
    wr(3, 9);
    base = xfer_cnt;
    done_pulse();
    n = 0;
    while (xfer_cnt - base < 2 && n < 20) begin
      tick();
      n++;
    end
    check("mid_drain_beats", xfer_cnt - base, 32'd2);
    rst = 1'b1;
    #1;
    check("rst_mid_drain", {3'd0, out_valid, out_last, out_addr, out_data, busy, sat_flag, wr_err}, 32'd0);
    check("rst_queue", exp_q.size(), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(pack(0, 0, 0));
    exp_q.push_back(pack(1, 4, 1));
    wr(1, 4);
    done_pulse();
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psum_sc_buffer.md
PSUM_SC_BUFFER -- requirements
Module: psum_sc_buffer

Interface
REQ-001 The parameter PSUM_SC_ADDR_LEN SHALL default to 8 and set the entry address width; DEPTH = 2**PSUM_SC_ADDR_LEN.
REQ-002 The parameter PSUM_W SHALL default to 16 and set the signed partial-sum width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 The port clk SHALL be an input, 1 bit: rising-edge clock.
REQ-005 The port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-006 The port psum_sc_wen SHALL be an input, 1 bit: write or accumulate the psum_in value at psum_sc_cnt_lead.
REQ-007 The port psum_sc_cnt_lead SHALL be an input, PSUM_SC_ADDR_LEN bits: target entry address.
REQ-008 The port psum_in SHALL be an input, PSUM_W bits: signed two's-complement partial sum.
REQ-009 The port psum_sc_done SHALL be an input, 1 bit: single-cycle pulse that ends accumulation and starts the drain.
REQ-010 The port out_valid SHALL be an output, 1 bit: drained entry is available.
REQ-011 The port out_ready SHALL be an input, 1 bit: consumer accepts the entry.
REQ-012 The port out_data SHALL be an output, PSUM_W bits: drained entry value.
REQ-013 The port out_addr SHALL be an output, PSUM_SC_ADDR_LEN bits: address of the drained entry.
REQ-014 The port out_last SHALL be an output, 1 bit: marks the final drained entry.
REQ-015 The port busy SHALL be an output, 1 bit: high in the DRAIN and CLEAR states.
REQ-016 The port sat_flag SHALL be an output, 1 bit: sticky flag set on any saturated accumulate.
REQ-017 The port wr_err SHALL be an output, 1 bit: sticky flag set when psum_sc_wen arrives while busy is high.

Function
REQ-018 The FSM SHALL have the states ACCUM, DRAIN and CLEAR, with ACCUM as the reset state.
REQ-019 In ACCUM, a psum_sc_wen with occupied[addr]=0 SHALL write psum_in and set occupied[addr] at the next clock edge.
REQ-020 In ACCUM, a psum_sc_wen with occupied[addr]=1 SHALL store mem[addr]+psum_in, saturated to the PSUM_W signed range.
REQ-021 On any saturation, the block SHALL set sat_flag and hold it until reset.
REQ-022 The block SHALL update hi_addr to the maximum address written since the last CLEAR.
REQ-023 On back-to-back psum_sc_wen to the same address, the second operation SHALL see the first result, with no lost update.
REQ-024 On psum_sc_done in ACCUM with at least one entry occupied, the FSM SHALL go to DRAIN and set the drain pointer to 0.
REQ-025 On psum_sc_done in ACCUM with no entry occupied, the FSM SHALL go directly to CLEAR and produce no output beat.
REQ-026 When psum_sc_wen and psum_sc_done occur in the same ACCUM cycle, the block SHALL commit the write first and include it in the drain.
REQ-027 In DRAIN, out_valid SHALL rise one cycle after entering DRAIN, and the block SHALL present entries at addresses 0..hi_addr in order.
REQ-028 During DRAIN, an unoccupied entry SHALL be output as out_data=0.
REQ-029 During DRAIN, out_addr SHALL equal the drain pointer, and out_last SHALL be 1 only when the pointer equals hi_addr.
REQ-030 The handshake rule SHALL be: a beat transfers when out_valid&&out_ready; while out_valid&&!out_ready, out_data, out_addr and out_last SHALL hold stable.
REQ-031 Once out_valid is asserted, it SHALL NOT drop before its transfer.
REQ-032 With out_ready held high, the block SHALL sustain one beat per cycle.
REQ-033 After the out_last transfer, the FSM SHALL go to CLEAR, where out_valid=0.
REQ-034 In CLEAR, which lasts 1 cycle, the block SHALL clear all occupied bits, set hi_addr=0, and then return to ACCUM.
REQ-035 While busy=1, psum_sc_wen SHALL be ignored and SHALL set wr_err.
REQ-036 While busy=1, psum_sc_done SHALL be ignored.
REQ-037 The drain pointer SHALL NOT wrap: the drain ends at hi_addr, including hi_addr=DEPTH-1.
REQ-038 Memory contents SHALL be defined only through the occupied bits and need no reset.

Reset
REQ-039 On rst, the block SHALL immediately force state=ACCUM, occupied=0, hi_addr=0, drain pointer=0, out_valid=0, out_last=0, out_data=0, out_addr=0, busy=0, sat_flag=0 and wr_err=0.
REQ-040 An rst asserted mid-DRAIN SHALL abort the drain with no further beats, and the next accumulation SHALL start from an empty buffer.

Verification
REQ-041 PSUM_W=16: wen addr3 +100, then wen addr3 -30, then done, out_ready=1 -> beats (0,0),(1,0),(2,0),(3,70), out_last on addr3, busy falls after CLEAR.
REQ-042 Wen addr0 32000 then addr0 +1000 -> stored value 32767 and sat_flag=1; repeat with -32000 and -1000 -> stored value -32768.
REQ-043 Drain of addr0..2 with out_ready toggling 1,0,0,1,0,1 -> exactly 3 transfers, outputs stable during the stalls, order preserved.
REQ-044 Wen addr5 +7 in the same cycle as done -> drain ends at addr5 with out_data=7; a wen pulse during DRAIN -> wr_err=1 and the memory is unchanged.
REQ-045 Done with an empty buffer -> no out_valid, busy=1 for exactly 1 cycle (CLEAR).
REQ-046 rst mid-DRAIN after 2 beats -> all outputs 0 immediately; then wen addr1 +4, done -> beats (0,0),(1,4) only.
